// File: rtl/pulse_seq_queue.sv
// Pulse sequencer with a small command queue: each command fires a burst of
// blank/emit/blank/receive pulses at an absolute start time and programs the DDS.
module pulse_seq_queue #(
  parameter int TW = 48,
  parameter int IW = 32,
  parameter int NW = 16,
  parameter int FW = 48,
  parameter int QD = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [TW-1:0]         TIME,
  input  logic                  WR_CMD,
  input  logic [TW-1:0]         C_START,
  input  logic [NW-1:0]         C_N,
  input  logic                  C_COH,
  input  logic [IW-1:0]         C_TB1,
  input  logic [IW-1:0]         C_TI,
  input  logic [IW-1:0]         C_TB2,
  input  logic [IW-1:0]         C_TP,
  input  logic [FW-1:0]         C_FREQ,
  input  logic                  ABORT,
  input  logic                  DDS_ACK,
  output logic                  DDS_REQ,
  output logic [FW-1:0]         DDS_FREQ,
  output logic                  DDS_START,
  output logic                  EN_IZ,
  output logic                  EN_PR,
  output logic                  BUSY,
  output logic [$clog2(QD):0]   Q_COUNT,
  output logic                  Q_FULL,
  output logic                  CMD_DONE,
  output logic                  CMD_LATE,
  output logic                  CMD_DROP
);

  localparam int AW = $clog2(QD);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [TW-1:0] start;
    logic [NW-1:0] n;
    logic          coh;
    logic [IW-1:0] tb1;
    logic [IW-1:0] ti;
    logic [IW-1:0] tb2;
    logic [IW-1:0] tp;
    logic [FW-1:0] freq;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_BLANK1, S_TIZL, S_BLANK2, S_TPR, S_NEXT
  } state_t;

  state_t state, next_state;

  cmd_t          mem [QD];
  cmd_t          head, c_in;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  logic [TW-1:0] w_start;
  logic          w_coh;
  logic [IW-1:0] w_tb1, w_ti, w_tb2, w_tp;
  logic [FW-1:0] w_freq;
  logic [NW-1:0] rem;
  logic [IW-1:0] cnt;
  logic          coh_run, req_pend;
  logic [TW-1:0] late_diff;
  logic          done_now, late_now, load_dds;

  // Phase counter reload value: a zero interval still occupies one cycle.
  function automatic logic [IW-1:0] ph_len(input logic [IW-1:0] v);
    return (v == '0) ? '0 : v - IW'(1);
  endfunction

  assign c_in = '{start: C_START, n: C_N, coh: C_COH, tb1: C_TB1, ti: C_TI,
                  tb2: C_TB2, tp: C_TP, freq: C_FREQ};
  assign head    = mem[rd_ptr];
  assign Q_COUNT = count;
  assign Q_FULL  = (count == CW'(QD));
  assign push    = WR_CMD && !Q_FULL && !ABORT;
  assign pop     = (state == S_IDLE) && (count != '0) && !ABORT;

  always_ff @(posedge CLK) begin
    if (push && !RESET) mem[wr_ptr] <= c_in;
  end

  always_ff @(posedge CLK) begin
    if (RESET || ABORT) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Late when the start time lies in the past half of the wrapping time space.
  assign late_diff = TIME - w_start;
  assign late_now  = (state == S_WAIT) && (late_diff != '0) && !late_diff[TW-1];
  assign done_now  = ((state == S_IDLE) && (count != '0) && (head.n == '0)) ||
                     ((state == S_NEXT) && (rem <= NW'(1)));
  assign load_dds  = (next_state == S_BLANK1) &&
                     ((state == S_WAIT) || ((state == S_NEXT) && !w_coh));

  always_ff @(posedge CLK) begin
    if (RESET || ABORT) state <= S_IDLE;
    else                state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if ((count != '0) && (head.n != '0)) next_state = S_WAIT;
      S_WAIT:   if (late_diff == '0)      next_state = S_BLANK1;
                else if (!late_diff[TW-1]) next_state = S_IDLE;
      S_BLANK1: if (cnt == '0) next_state = S_TIZL;
      S_TIZL:   if (cnt == '0) next_state = S_BLANK2;
      S_BLANK2: if (cnt == '0) next_state = S_TPR;
      S_TPR:    if (cnt == '0) next_state = S_NEXT;
      S_NEXT:   next_state = (rem > NW'(1)) ? S_BLANK1 : S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    EN_IZ     = (state == S_TIZL);
    EN_PR     = (state == S_TPR);
    BUSY      = (state != S_IDLE);
    DDS_START = (state == S_TIZL) || coh_run;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      w_start  <= '0;
      w_coh    <= 1'b0;
      w_tb1    <= '0;
      w_ti     <= '0;
      w_tb2    <= '0;
      w_tp     <= '0;
      w_freq   <= '0;
      rem      <= '0;
      cnt      <= '0;
      coh_run  <= 1'b0;
      req_pend <= 1'b0;
      DDS_REQ  <= 1'b0;
      DDS_FREQ <= '0;
      CMD_DONE <= 1'b0;
      CMD_LATE <= 1'b0;
      CMD_DROP <= 1'b0;
    end else begin
      CMD_DONE <= done_now && !ABORT;
      CMD_LATE <= late_now && !ABORT;
      CMD_DROP <= WR_CMD && Q_FULL && !ABORT;
      if (ABORT) begin
        rem      <= '0;
        cnt      <= '0;
        coh_run  <= 1'b0;
        req_pend <= 1'b0;
        DDS_REQ  <= 1'b0;
      end else begin
        if (pop) begin
          w_start <= head.start;
          w_coh   <= head.coh;
          w_tb1   <= head.tb1;
          w_ti    <= head.ti;
          w_tb2   <= head.tb2;
          w_tp    <= head.tp;
          w_freq  <= head.freq;
          rem     <= head.n;
        end
        if (state == S_NEXT) rem <= rem - NW'(1);

        if (next_state != state) begin
          case (next_state)
            S_BLANK1: cnt <= ph_len(w_tb1);
            S_TIZL:   cnt <= ph_len(w_ti);
            S_BLANK2: cnt <= ph_len(w_tb2);
            S_TPR:    cnt <= ph_len(w_tp);
            default:  cnt <= '0;
          endcase
        end else if (cnt != '0) begin
          cnt <= cnt - IW'(1);
        end

        // Coherent bursts keep the DDS running between pulses until the last emit ends.
        if ((state == S_TIZL) && (next_state != S_TIZL))
          coh_run <= w_coh && (rem > NW'(1));
        else if (state == S_IDLE)
          coh_run <= 1'b0;

        // Four-phase handshake; a request that cannot start yet is held pending
        // so pulse timing never waits on the DDS.
        if (state == S_IDLE) req_pend <= 1'b0;
        if (DDS_REQ) begin
          if (DDS_ACK) DDS_REQ <= 1'b0;
        end else if ((load_dds || req_pend) && !DDS_ACK) begin
          DDS_REQ  <= 1'b1;
          DDS_FREQ <= w_freq;
          req_pend <= 1'b0;
        end
        if (load_dds && (DDS_REQ || DDS_ACK)) req_pend <= 1'b1;
      end
    end
  end

endmodule
